// File: rtl/phase_gen.sv
`default_nettype none
// ============================================================================
// Module   : phase_gen
// Purpose  : Multi-cycle CPU phase sequencer. Walks each instruction through
//            fetch-wait, F, R, X, M and W, drives the one-hot phase bus,
//            owns the instruction/data memory handshakes and run/halt
//            control, and keeps the active-cycle and retired-instruction
//            counters.
// Ports    : clk        - clock, rising edge
//            n_rst      - asynchronous active-low reset
//            run        - 1 = execute, 0 = stop at next instruction boundary
//            halt_req   - decoder: current instruction is HALT (valid in R)
//            mem_op     - decoder: instruction accesses data memory (R..M)
//            i_ack      - instruction word ready (used only in IW)
//            d_ack      - data access complete (used only while d_req=1)
//            phase      - one-hot {w,m,x,r,f}; zero in IDLE, IW and HALT
//            i_req      - instruction fetch request
//            d_req      - data memory request
//            running    - 1 in every state except IDLE and HALT
//            retire     - 1 for the single W cycle of each instruction
//            cycle_cnt  - active-cycle counter (wraps)
//            inst_cnt   - retired-instruction counter (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module phase_gen #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             run,
  input  logic             halt_req,
  input  logic             mem_op,
  input  logic             i_ack,
  input  logic             d_ack,
  output logic [4:0]       phase,
  output logic             i_req,
  output logic             d_req,
  output logic             running,
  output logic             retire,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] inst_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_IW   = 3'd1,
    ST_F    = 3'd2,
    ST_R    = 3'd3,
    ST_X    = 3'd4,
    ST_M    = 3'd5,
    ST_W    = 3'd6,
    ST_HALT = 3'd7
  } state_t;

  localparam logic [4:0] C_PH_NONE = 5'b00000;
  localparam logic [4:0] C_PH_F    = 5'b00001;
  localparam logic [4:0] C_PH_R    = 5'b00010;
  localparam logic [4:0] C_PH_X    = 5'b00100;
  localparam logic [4:0] C_PH_M    = 5'b01000;
  localparam logic [4:0] C_PH_W    = 5'b10000;

  state_t           r_state;
  state_t           w_next;
  logic             r_halt_flag;
  logic             r_mem_op;
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_inst_cnt;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (run) w_next = ST_IW;
      // A fetch, once requested, is never withdrawn: run is not consulted.
      ST_IW:   if (i_ack) w_next = ST_F;
      ST_F:    w_next = ST_R;
      ST_R:    w_next = ST_X;
      ST_X:    w_next = ST_M;
      ST_M:    if (!r_mem_op || d_ack) w_next = ST_W;
      ST_W: begin
        if (r_halt_flag) begin
          w_next = ST_HALT;
        end else if (!run) begin
          w_next = ST_IDLE;
        end else begin
          w_next = ST_IW;
        end
      end
      ST_HALT: if (!run) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Decoder side-band captures. mem_op is stable from R through M, so it is
  // latched on leaving X; d_req and the M exit then depend only on registered
  // state and no input reaches an output combinationally.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_halt_flag <= 1'b0;
      r_mem_op    <= 1'b0;
    end else begin
      if (r_state == ST_R) begin
        r_halt_flag <= halt_req;
      end else if (w_next == ST_IDLE) begin
        r_halt_flag <= 1'b0;
      end
      if (r_state == ST_X) begin
        r_mem_op <= mem_op;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Counters: free-running modulo 2^CNT_W, cleared only by reset.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_cycle_cnt <= '0;
      r_inst_cnt  <= '0;
    end else begin
      if (r_state != ST_IDLE && r_state != ST_HALT) begin
        r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
      end
      if (r_state == ST_W) begin
        r_inst_cnt <= r_inst_cnt + CNT_W'(1);
      end
    end
  end

  assign cycle_cnt = r_cycle_cnt;
  assign inst_cnt  = r_inst_cnt;

  // --------------------------------------------------------------------------
  // Moore output decode
  // --------------------------------------------------------------------------
  always_comb begin
    phase   = C_PH_NONE;
    i_req   = 1'b0;
    d_req   = 1'b0;
    running = 1'b1;
    retire  = 1'b0;
    case (r_state)
      ST_IDLE: running = 1'b0;
      ST_IW:   i_req   = 1'b1;
      ST_F:    phase   = C_PH_F;
      ST_R:    phase   = C_PH_R;
      ST_X:    phase   = C_PH_X;
      ST_M: begin
        phase = C_PH_M;
        d_req = r_mem_op;
      end
      ST_W: begin
        phase  = C_PH_W;
        retire = 1'b1;
      end
      ST_HALT: running = 1'b0;
      default: running = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_phase_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_phase_gen
// Purpose  : Self-checking bench for phase_gen. Expected per-cycle output
//            vectors are queued as stimulus is applied and compared on the
//            following falling edge; counters and a PC model are tracked
//            alongside. A second instance with CNT_W=4 shares all inputs to
//            exercise counter wrap.
// Revision : 1.0 - initial release
// ============================================================================
module tb_phase_gen;

  logic        clk      = 1'b0;
  logic        n_rst    = 1'b0;
  logic        run      = 1'b0;
  logic        halt_req = 1'b0;
  logic        mem_op   = 1'b0;
  logic        i_ack    = 1'b0;
  logic        d_ack    = 1'b0;

  logic [4:0]  phase;
  logic        i_req, d_req, running, retire;
  logic [31:0] cycle_cnt, inst_cnt;

  logic [4:0]  phase4;
  logic        i_req4, d_req4, running4, retire4;
  logic [3:0]  cycle_cnt4, inst_cnt4;

  phase_gen #(.CNT_W(32)) dut (
    .clk(clk), .n_rst(n_rst), .run(run), .halt_req(halt_req),
    .mem_op(mem_op), .i_ack(i_ack), .d_ack(d_ack),
    .phase(phase), .i_req(i_req), .d_req(d_req), .running(running),
    .retire(retire), .cycle_cnt(cycle_cnt), .inst_cnt(inst_cnt)
  );

  phase_gen #(.CNT_W(4)) dut4 (
    .clk(clk), .n_rst(n_rst), .run(run), .halt_req(halt_req),
    .mem_op(mem_op), .i_ack(i_ack), .d_ack(d_ack),
    .phase(phase4), .i_req(i_req4), .d_req(d_req4), .running(running4),
    .retire(retire4), .cycle_cnt(cycle_cnt4), .inst_cnt(inst_cnt4)
  );

  always #5 clk = ~clk;

  // Expected vector layout: {phase[4:0], i_req, d_req, running, retire}
  localparam logic [8:0] E_IDLE = {5'b00000, 4'b0000};
  localparam logic [8:0] E_HALT = {5'b00000, 4'b0000};
  localparam logic [8:0] E_IW   = {5'b00000, 4'b1010};
  localparam logic [8:0] E_F    = {5'b00001, 4'b0010};
  localparam logic [8:0] E_R    = {5'b00010, 4'b0010};
  localparam logic [8:0] E_X    = {5'b00100, 4'b0010};
  localparam logic [8:0] E_M0   = {5'b01000, 4'b0010};
  localparam logic [8:0] E_M1   = {5'b01000, 4'b0110};
  localparam logic [8:0] E_W    = {5'b10000, 4'b0011};

  logic [8:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int exp_cyc  = 0;
  int exp_inst = 0;
  int pc       = 0;

  // External PC register: +4 on every clock with phase[f]=1.
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) pc <= 0;
    else if (phase[0]) pc <= pc + 4;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  // Queue the expectation for the next cycle, advance one clock, then pop
  // and compare against what the DUT shows.
  task automatic step(input logic [8:0] e);
    logic [8:0] x;
    exp_q.push_back(e);
    @(negedge clk);
    x = exp_q.pop_front();
    check("outputs", {phase, i_req, d_req, running, retire}, x);
    check("onehot0", $onehot0(phase), 1);
    check("cycle_cnt", cycle_cnt, exp_cyc);
    check("inst_cnt", inst_cnt, exp_inst);
    check("inst_cnt_w4", inst_cnt4, exp_inst % 16);
    check("cycle_cnt_w4", cycle_cnt4, exp_cyc % 16);
    exp_cyc  += int'(x[1]);
    exp_inst += int'(x[0]);
  endtask

  // Entered on the falling edge of the first IW cycle; returns on the
  // falling edge of the W cycle.
  task automatic run_instr(input int iw_extra, input bit mem, input int m_extra,
                           input bit hlt, input bit drop_run);
    int pc0;
    pc0 = pc;
    for (int k = 0; k < iw_extra; k++) begin
      i_ack = 1'b0;
      step(E_IW);
    end
    i_ack = 1'b1;
    step(E_F);
    halt_req = hlt;
    mem_op   = mem;
    step(E_R);
    step(E_X);
    halt_req = 1'b0;
    if (drop_run) run = 1'b0;
    step(mem ? E_M1 : E_M0);
    if (mem) begin
      for (int k = 0; k < m_extra; k++) begin
        d_ack = 1'b0;
        step(E_M1);
      end
      d_ack = 1'b1;
    end
    step(E_W);
    mem_op = 1'b0;
    check("pc_step", pc, pc0 + 4);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_outputs", {phase, i_req, d_req, running, retire}, 0);
    check("rst_cycle_cnt", cycle_cnt, 0);
    check("rst_inst_cnt", inst_cnt, 0);
    n_rst = 1'b1;
    step(E_IDLE);

    // Back-to-back instructions with every handshake held high
    run = 1'b1; i_ack = 1'b1; d_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(E_IW);
      run_instr(0, 1'b0, 0, 1'b0, 1'b0);
    end
    step(E_IW);
    check("cyc_after_3", cycle_cnt, 18);
    check("inst_after_3", inst_cnt, 3);

    // Instruction fetch acknowledged 4 cycles late
    run_instr(4, 1'b0, 0, 1'b0, 1'b0);

    // Data access with d_ack 3 cycles into M
    step(E_IW);
    run_instr(0, 1'b1, 3, 1'b0, 1'b0);

    // run dropped during X: completes, then parks in IDLE with no fetch
    step(E_IW);
    run_instr(0, 1'b0, 0, 1'b0, 1'b1);
    repeat (3) step(E_IDLE);

    // run dropped while waiting in IW: fetch is still completed
    run = 1'b1;
    step(E_IW);
    run = 1'b0;
    run_instr(2, 1'b0, 0, 1'b0, 1'b0);
    step(E_IDLE);

    // Asynchronous reset in the middle of a data access
    run = 1'b1;
    step(E_IW);
    i_ack = 1'b1;
    step(E_F);
    mem_op = 1'b1;
    step(E_R);
    step(E_X);
    d_ack = 1'b0;
    step(E_M1);
    #2 n_rst = 1'b0;
    #1;
    check("async_rst_outputs", {phase, i_req, d_req, running, retire}, 0);
    check("async_rst_cycle", cycle_cnt, 0);
    check("async_rst_inst", inst_cnt, 0);
    exp_cyc  = 0;
    exp_inst = 0;
    @(negedge clk);
    n_rst = 1'b1; mem_op = 1'b0; d_ack = 1'b1;
    step(E_IW);
    run_instr(0, 1'b0, 0, 1'b0, 1'b0);

    // HALT on the second instruction after reset
    step(E_IW);
    run_instr(0, 1'b0, 0, 1'b1, 1'b0);
    step(E_HALT);
    check("halt_inst_cnt", inst_cnt, 2);
    repeat (3) step(E_HALT);
    check("halt_cyc_frozen", cycle_cnt, 12);
    run = 1'b0;
    step(E_IDLE);
    run = 1'b1;
    step(E_IW);
    run_instr(0, 1'b0, 0, 1'b0, 1'b0);

    // Continue to 16 retired instructions: 4-bit counter wraps 15 -> 0
    for (int i = 0; i < 13; i++) begin
      step(E_IW);
      run_instr(0, 1'b0, 0, 1'b0, 1'b0);
    end
    step(E_IW);
    check("wrap_inst_w4", inst_cnt4, 0);
    check("wrap_inst_w32", inst_cnt, 16);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
